// File: rtl/bin2bcd_if.sv
// bin2bcd_if: request/result bundle for the sequential binary-to-BCD converter.
//   master : drives start/bin, observes busy/done/bcd/overflow
//   slave  : the converter side
//   start    - conversion request, honoured only while busy is low
//   bin      - W-bit unsigned operand, captured on the accepting edge
//   busy     - conversion in progress
//   done     - one-cycle completion pulse
//   bcd      - packed BCD result, digit 0 in bits [3:0]
//   overflow - operand exceeded 10^DIGITS-1 (bcd holds value mod 10^DIGITS)
interface bin2bcd_if #(
    parameter int W      = 8,
    parameter int DIGITS = 3
) ();
    logic                  start;
    logic [W-1:0]          bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  overflow;

    modport master (
        output start, bin,
        input  busy, done, bcd, overflow
    );

    modport slave (
        input  start, bin,
        output busy, done, bcd, overflow
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: double-dabble (shift-and-add-3) binary-to-BCD converter,
// one operand bit per clock.
//   clk   - system clock, rising edge
//   rst_n - synchronous active-low reset
//   bus   - bin2bcd_if slave: start/bin in, busy/done/bcd/overflow out
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start
// SHIFT  | one adjust-and-shift step per edge, W steps in total
// DONE   | result just presented (done=1); start here is accepted
module bin2bcd_seq #(
    parameter int W      = 8,
    parameter int DIGITS = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    bin2bcd_if.slave   bus
);
    localparam int SW = 4 * DIGITS;
    localparam int CW = (W < 2) ? 1 : $clog2(W + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    shift_q, shift_d;
    logic [SW-1:0]   scratch_q, scratch_d;
    logic            sticky_q, sticky_d;
    logic [CW-1:0]   count_q, count_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [SW-1:0]   bcd_q, bcd_d;
    logic            ovf_q, ovf_d;

    logic [SW-1:0]   adj;
    logic [SW+W-1:0] stepped;
    logic            ovf_step;

    // Digit adjust: each nibble >= 5 gets +3 so the following shift carries
    // into the next digit exactly when the doubled digit reaches 10.
    always_comb begin
        adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end else begin
                adj[4*i +: 4] = scratch_q[4*i +: 4];
            end
        end
        stepped  = {adj, shift_q} << 1;
        // The bit leaving the top digit is a carry worth 10^DIGITS.
        ovf_step = sticky_q | adj[SW-1];
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        sticky_d  = sticky_q;
        count_d   = count_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    shift_d   = bus.bin;
                    scratch_d = '0;
                    sticky_d  = 1'b0;
                    count_d   = '0;
                    busy_d    = 1'b1;
                    state_d   = S_SHIFT;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_SHIFT: begin
                scratch_d = stepped[SW+W-1:W];
                shift_d   = stepped[W-1:0];
                sticky_d  = ovf_step;
                count_d   = count_q + CW'(1);
                if (count_q == CW'(W - 1)) begin
                    bcd_d   = stepped[SW+W-1:W];
                    ovf_d   = ovf_step;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            sticky_q  <= 1'b0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            sticky_q  <= sticky_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.bcd      = bcd_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: three converter instances (8b/3 digits, 8b/2 digits,
// 16b/5 digits) on one clock, checked against a decimal-arithmetic model.
module tb_bin2bcd_seq;
    logic clk;
    logic rst_n;

    logic              st [3];
    logic [31:0]       bi [3];
    logic              dn [3];
    logic              bz [3];
    logic              ov [3];
    logic [63:0]       bc [3];

    int wk [3] = '{8, 8, 16};
    int dg [3] = '{3, 2, 5};

    int n_cmp = 0;
    int n_err = 0;

    bin2bcd_if #(.W(8),  .DIGITS(3)) if8  ();
    bin2bcd_if #(.W(8),  .DIGITS(2)) if82 ();
    bin2bcd_if #(.W(16), .DIGITS(5)) if16 ();

    bin2bcd_seq #(.W(8),  .DIGITS(3)) u_d8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
    bin2bcd_seq #(.W(8),  .DIGITS(2)) u_d82 (.clk(clk), .rst_n(rst_n), .bus(if82.slave));
    bin2bcd_seq #(.W(16), .DIGITS(5)) u_d16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));

    assign if8.start  = st[0];
    assign if8.bin    = bi[0][7:0];
    assign if82.start = st[1];
    assign if82.bin   = bi[1][7:0];
    assign if16.start = st[2];
    assign if16.bin   = bi[2][15:0];

    assign dn[0] = if8.done;
    assign dn[1] = if82.done;
    assign dn[2] = if16.done;
    assign bz[0] = if8.busy;
    assign bz[1] = if82.busy;
    assign bz[2] = if16.busy;
    assign ov[0] = if8.overflow;
    assign ov[1] = if82.overflow;
    assign ov[2] = if16.overflow;
    assign bc[0] = 64'(if8.bcd);
    assign bc[1] = 64'(if82.bcd);
    assign bc[2] = 64'(if16.bcd);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Decimal digits of v, least significant first, truncated to d digits.
    function automatic logic [63:0] ref_bcd(input longint unsigned v, input int d);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input longint unsigned v, input int d);
        longint unsigned lim;
        lim = 1;
        for (int i = 0; i < d; i++) lim = lim * 10;
        return (v >= lim);
    endfunction

    // One isolated conversion on instance k: latency, busy length, result
    // hold during the conversion, result values, single-cycle done.
    task automatic convert(input int k, input int unsigned v);
        int          c;
        int          nb;
        logic [63:0] prev;
        logic        changed;
        prev    = bc[k];
        changed = 1'b0;
        nb      = 0;
        @(negedge clk);
        st[k] = 1'b1;
        bi[k] = v;
        @(negedge clk);
        st[k] = 1'b0;
        bi[k] = $urandom;
        c = 1;
        while (!dn[k] && c < 100) begin
            if (bz[k]) nb++;
            if (bc[k] !== prev) changed = 1'b1;
            @(negedge clk);
            bi[k] = $urandom;
            c++;
        end
        check("latency", c - 1, wk[k]);
        check("busy_len", nb, wk[k]);
        check("hold", changed, 1'b0);
        check("bcd", bc[k], ref_bcd(v, dg[k]));
        check("ovf", ov[k], ref_ovf(v, dg[k]));
        @(negedge clk);
        check("done_pulse", dn[k], 1'b0);
    endtask

    // start held high on instance 0 while bin changes every cycle; the
    // model accepts whenever it is not mid-conversion, including the
    // done cycle itself.
    task automatic held_run();
        int          rem;
        logic        eb;
        logic        ed;
        int unsigned q[$];
        int unsigned cur;
        rem = 0;
        eb  = 1'b0;
        ed  = 1'b0;
        for (int cyc = 0; cyc < 5 * 8 + 14; cyc++) begin
            @(negedge clk);
            if (cyc > 0) begin
                check("held_busy", bz[0], eb);
                check("held_done", dn[0], ed);
                if (ed && q.size() > 0) begin
                    cur = q.pop_front();
                    check("held_bcd", bc[0], ref_bcd(cur, 3));
                end
            end
            st[0] = (cyc < 5 * 8);
            bi[0] = $urandom_range(0, 255);
            ed = 1'b0;
            if (rem == 0) begin
                if (st[0]) begin
                    q.push_back(bi[0]);
                    rem = 8;
                    eb  = 1'b1;
                end else begin
                    eb  = 1'b0;
                end
            end else begin
                rem--;
                if (rem == 0) begin
                    ed = 1'b1;
                    eb = 1'b0;
                end
            end
        end
        st[0] = 1'b0;
    endtask

    initial begin
        int unsigned vals [3];
        int          c;
        int          nd;
        int unsigned sweep [7];

        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            st[k] = 1'b0;
            bi[k] = '0;
        end
        repeat (3) @(negedge clk);
        check("rst_busy", bz[0], 1'b0);
        check("rst_done", dn[0], 1'b0);
        check("rst_bcd", bc[0], 64'h0);
        check("rst_ovf", ov[0], 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        convert(0, 255);

        // Back-to-back: the next start is raised in each done cycle, so the
        // following accept lands on the edge after done and done pulses
        // repeat every W+1 edges.
        vals = '{0, 9, 100};
        @(negedge clk);
        st[0] = 1'b1;
        bi[0] = vals[0];
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            st[0] = 1'b0;
            c = 1;
            while (!dn[0] && c < 100) begin
                @(negedge clk);
                c++;
            end
            check("b2b_gap", c, 9);
            check("b2b_bcd", bc[0], ref_bcd(vals[i], 3));
            check("b2b_ovf", ov[0], 1'b0);
            if (i < 2) begin
                st[0] = 1'b1;
                bi[0] = vals[i + 1];
            end
        end

        convert(1, 123);
        convert(1, 99);
        convert(1, 100);

        @(negedge clk);
        held_run();

        // Reset on the fourth shift step of a conversion of 200.
        @(negedge clk);
        st[0] = 1'b1;
        bi[0] = 200;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_busy", bz[0], 1'b0);
        check("midrst_done", dn[0], 1'b0);
        check("midrst_bcd", bc[0], 64'h0);
        check("midrst_ovf", ov[0], 1'b0);
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (dn[0]) nd++;
        end
        check("midrst_nodone", nd, 0);
        convert(0, 42);

        // Reset and start on the same edge: reset wins.
        @(negedge clk);
        st[0] = 1'b1;
        bi[0] = 77;
        rst_n = 1'b0;
        @(negedge clk);
        st[0] = 1'b0;
        rst_n = 1'b1;
        check("rst_vs_start", bz[0], 1'b0);
        @(negedge clk);
        check("rst_vs_start2", bz[0], 1'b0);

        sweep = '{0, 1, 9, 10, 9999, 10000, 65535};
        for (int i = 0; i < 7; i++) convert(2, sweep[i]);
        for (int i = 0; i < 150; i++) convert(2, $urandom_range(0, 65535));
        for (int i = 0; i < 30; i++) convert(0, $urandom_range(0, 255));
        for (int i = 0; i < 30; i++) convert(1, $urandom_range(0, 255));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
